rd_fwft_stage: RTL

RD_FWFT_STAGE -- requirements
Module: rd_fwft_stage

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/rd_fwft_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stages: default word width,
// the first-word-fall-through buffer state type and the stall counter width.
package fifo_pkg;

  // Default FIFO word width in bits.
  localparam int data_width_default = 8;

  // Width of the optional stall cycle counter.
  localparam int stall_cnt_width = 16;

  // Occupancy of the two-entry output buffer (head, tail).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } fwft_state_t;

  // Number of words currently held in the output buffer for a given state.
  function automatic logic [1:0] state_occupancy(input fwft_state_t state);
    logic [1:0] occ;
    occ = 2'd0;
    case (state)
      S_EMPTY: occ = 2'd0;
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/rd_fwft_stage.sv
// rd_fwft_stage: turns the empty/rd_en pop interface of a synchronous-RAM
// FIFO into a first-word-fall-through valid/ready stream.
//
// A two-entry buffer (head, tail) absorbs the one-cycle RAM read latency so
// that a word can leave every cycle while the consumer is ready. A pop is only
// issued when the buffer is guaranteed room for the word once it returns from
// the RAM, so at most two words are ever buffered or in flight.
//
// Optional feature, enabled by defining RD_FWFT_STALL_CNT_EN:
//   adds the stall_cnt output, a saturating count of cycles in which a valid
//   word was held back because the consumer was not ready.
module rd_fwft_stage
  import fifo_pkg::*;
#(
  parameter int Data_Width = data_width_default
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [Data_Width-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Data_Width-1:0] out_data
`ifdef RD_FWFT_STALL_CNT_EN
  ,
  output logic [stall_cnt_width-1:0] stall_cnt
`endif
);

  fwft_state_t           state;
  logic                  inflight;
  logic [Data_Width-1:0] head;
  logic [Data_Width-1:0] tail;

  logic                  drain;
  logic                  arrive;
  logic [1:0]            occupancy;
  logic [2:0]            committed;
  logic [2:0]            pop_limit;

  // A word leaves when it is presented and the consumer takes it; a word
  // arrives from the RAM exactly one cycle after an accepted pop.
  assign drain  = out_valid & out_ready;
  assign arrive = inflight;

  // Words already owned by this stage: buffered plus the one returning from RAM.
  assign occupancy = state_occupancy(state);
  assign committed = {1'b0, occupancy} + {2'b00, inflight};

  // Popping is safe when, after this cycle's drain, at most one word is owned,
  // leaving room for the new one. Written as committed <= 1 + drain so the
  // arithmetic never goes negative. Held low during reset and while empty.
  assign pop_limit = {2'b00, drain} + 3'd1;
  assign rd_en     = rd_rstn & ~empty & (committed <= pop_limit);

  // The head register is the output word; it only changes on arrive or drain,
  // which keeps the output frozen while the consumer stalls.
  assign out_data = head;

  // Track whether a pop issued last cycle has its data on mem_rdata now.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
    end
  end

  // Buffer occupancy FSM: captures returning RAM words into head or tail,
  // shifts tail into head on drain, and registers out_valid with the state.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      head      <= '0;
      tail      <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (arrive) begin
            head      <= mem_rdata;
            state     <= S_ONE;
            out_valid <= 1'b1;
          end
        end

        S_ONE: begin
          case ({arrive, drain})
            2'b10: begin
              tail  <= mem_rdata;
              state <= S_TWO;
            end
            2'b01: begin
              state     <= S_EMPTY;
              out_valid <= 1'b0;
            end
            2'b11: begin
              head <= mem_rdata;
            end
            default: begin
            end
          endcase
        end

        S_TWO: begin
          if (drain) begin
            head  <= tail;
            state <= S_ONE;
          end
        end

        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RD_FWFT_STALL_CNT_EN
  logic stall;

  // A stall is a cycle where a valid word waits on the consumer.
  assign stall = out_valid & ~out_ready;

  // Saturating stall cycle counter; it sticks at all-ones instead of wrapping.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {stall_cnt_width{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  // A word can never return while both buffer entries are full, because no
  // pop is issued when the buffer plus in-flight word would exceed two.
  property no_arrive_when_full;
    @(posedge rd_clk) disable iff (!rd_rstn)
      !((state == S_TWO) && inflight);
  endproperty
  assert property (no_arrive_when_full);

  // The registered valid flag always mirrors a non-empty buffer.
  property valid_matches_state;
    @(posedge rd_clk) disable iff (!rd_rstn)
      out_valid == (state != S_EMPTY);
  endproperty
  assert property (valid_matches_state);

endmodule
